sim_run_controller: RTL and testbench

Cycle-level run controller for the simulation top. It sequences reset release for the main and derived domains after a fixed hold period. It gates the design's run enable with pause and single-step inputs, counts enabled cycles, and converts a finish request from the host cycle hook into a drained, sticky finish indication. It sits between the testbench clock/reset generators and the simulated top-level, replacing ad hoc reset and finish counters.

---
 rtl/sim_run_controller.sv | 102 ++++++++++
 tb/tb_sim_run_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sim_run_controller.sv
// sim_run_controller: sequences core/derived reset release, gates run enable with pause/step,
// counts enabled cycles and turns a finish request into a drained, sticky finish.
module sim_run_controller #(
    parameter int RESET_CYCLES = 20,
    parameter int DERIVED_LAG  = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   finish_req,
    input  logic                   pause,
    input  logic                   step,
    output logic                   core_rst_n,
    output logic                   derived_rst_n,
    output logic                   run_en,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic                   finish,
    output logic [2:0]             state
);
    localparam int MAX_LEN = (RESET_CYCLES > DERIVED_LAG ? (RESET_CYCLES > DRAIN_CYCLES ? RESET_CYCLES : DRAIN_CYCLES)
                                                         : (DERIVED_LAG > DRAIN_CYCLES ? DERIVED_LAG : DRAIN_CYCLES));
    localparam int CW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] HOLD_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] LAG_LAST   = CW'(DERIVED_LAG - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    typedef enum logic [2:0] {HOLD = 3'd0, LAG = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4} state_t;
    state_t        st;
    logic [CW-1:0] cnt;
    logic          finish_pending;
    assign state = st;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st             <= HOLD;
            cnt            <= '0;
            finish_pending <= 1'b0;
            core_rst_n     <= 1'b0;
            derived_rst_n  <= 1'b0;
            run_en         <= 1'b0;
            cycle_count    <= '0;
            finish         <= 1'b0;
        end else begin
            if (run_en)
                cycle_count <= cycle_count + COUNT_WIDTH'(1);
            case (st)
                HOLD: begin
                    if (finish_req)
                        finish_pending <= 1'b1;
                    if (cnt == HOLD_LAST) begin
                        cnt        <= '0;
                        core_rst_n <= 1'b1;
                        if (DERIVED_LAG == 0) begin
                            derived_rst_n <= 1'b1;
                            st            <= RUN;
                        end else
                            st <= LAG;
                    end else
                        cnt <= cnt + CW'(1);
                end
                LAG: begin
                    if (finish_req)
                        finish_pending <= 1'b1;
                    if (cnt == LAG_LAST) begin
                        cnt           <= '0;
                        derived_rst_n <= 1'b1;
                        st            <= RUN;
                    end else
                        cnt <= cnt + CW'(1);
                end
                RUN: begin
                    if (finish_req || finish_pending) begin
                        finish_pending <= 1'b0;
                        cnt            <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            st     <= DONE;
                            run_en <= 1'b0;
                            finish <= 1'b1;
                        end else begin
                            st     <= DRAIN;
                            run_en <= 1'b1;
                        end
                    end else
                        run_en <= !pause || step;
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        st     <= DONE;
                        run_en <= 1'b0;
                        finish <= 1'b1;
                    end else begin
                        cnt    <= cnt + CW'(1);
                        run_en <= 1'b1;
                    end
                end
                default: begin
                    run_en <= 1'b0;
                    finish <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller: directed vectors for the run controller, default and degenerate parameterisations.
module tb_sim_run_controller;
    logic        CLK = 1'b0;
    logic        rst_n, finish_req, pause, step;
    logic        core_rst_n, derived_rst_n, run_en, finish;
    logic [31:0] cycle_count;
    logic [2:0]  state;
    logic        rst_n_w, finish_req_w;
    logic        core_rst_n_w, derived_rst_n_w, run_en_w, finish_w;
    logic [3:0]  cycle_count_w;
    logic [2:0]  state_w;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 CLK = ~CLK;

    sim_run_controller dut (
        .CLK(CLK), .RST_N(rst_n), .finish_req(finish_req), .pause(pause), .step(step),
        .core_rst_n(core_rst_n), .derived_rst_n(derived_rst_n), .run_en(run_en),
        .cycle_count(cycle_count), .finish(finish), .state(state)
    );

    sim_run_controller #(.DERIVED_LAG(0), .DRAIN_CYCLES(0), .COUNT_WIDTH(4)) dut_w (
        .CLK(CLK), .RST_N(rst_n_w), .finish_req(finish_req_w), .pause(1'b0), .step(1'b0),
        .core_rst_n(core_rst_n_w), .derived_rst_n(derived_rst_n_w), .run_en(run_en_w),
        .cycle_count(cycle_count_w), .finish(finish_w), .state(state_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic release_rst;
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        logic fin_all;
        rst_n = 0; finish_req = 0; pause = 0; step = 0;
        rst_n_w = 0; finish_req_w = 0;
        tick(2);
        chk("rst_core", core_rst_n, 0);
        chk("rst_derived", derived_rst_n, 0);
        chk("rst_run_en", run_en, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_finish", finish, 0);
        chk("rst_state", state, 0);
        // normal bring-up
        release_rst();
        tick(19);
        chk("e19_core", core_rst_n, 0);
        chk("e19_state", state, 0);
        tick(1);
        chk("e20_core", core_rst_n, 1);
        chk("e20_derived", derived_rst_n, 0);
        chk("e20_state", state, 1);
        tick(3);
        chk("e23_derived", derived_rst_n, 0);
        tick(1);
        chk("e24_derived", derived_rst_n, 1);
        chk("e24_state", state, 2);
        chk("e24_run_en", run_en, 0);
        tick(1);
        chk("e25_run_en", run_en, 1);
        chk("e25_count", cycle_count, 0);
        tick(3);
        chk("e28_count", cycle_count, 3);
        // pause with two step pulses
        pause = 1;
        tick(1);
        chk("e29_run_en", run_en, 0);
        chk("e29_count", cycle_count, 4);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            step = (i == 2 || i == 6);
            tick(1);
            step = 0;
            hi += int'(run_en);
        end
        chk("pause_hi_edges", hi, 2);
        chk("e39_count", cycle_count, 6);
        // one-cycle finish request while paused
        finish_req = 1;
        tick(1);
        finish_req = 0;
        chk("e40_state", state, 3);
        hi = int'(run_en);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            hi += int'(run_en);
        end
        chk("drain_hi_edges", hi, 8);
        chk("e47_finish", finish, 0);
        tick(1);
        chk("e48_run_en", run_en, 0);
        chk("e48_finish", finish, 1);
        chk("e48_state", state, 4);
        chk("e48_count", cycle_count, 14);
        fin_all = 1;
        for (int i = 0; i < 50; i++) begin
            finish_req = i[0];
            pause = i[1];
            tick(1);
            fin_all &= finish;
        end
        finish_req = 0; pause = 0;
        chk("done_sticky", fin_all, 1);
        chk("done_count", cycle_count, 14);
        chk("done_run_en", run_en, 0);
        // finish request during HOLD is remembered
        #2 rst_n = 0;
        #1;
        chk("rst2_finish", finish, 0);
        chk("rst2_state", state, 0);
        release_rst();
        tick(4);
        finish_req = 1;
        tick(1);
        finish_req = 0;
        tick(19);
        chk("pend_e24_state", state, 2);
        tick(1);
        chk("pend_e25_state", state, 3);
        chk("pend_e25_run_en", run_en, 1);
        tick(7);
        chk("pend_e32_finish", finish, 0);
        tick(1);
        chk("pend_e33_finish", finish, 1);
        // asynchronous reset in the middle of DRAIN
        #2 rst_n = 0;
        #1;
        release_rst();
        tick(24);
        finish_req = 1;
        tick(1);
        finish_req = 0;
        tick(3);
        chk("mid_drain_state", state, 3);
        #2 rst_n = 0;
        #1;
        chk("async_core", core_rst_n, 0);
        chk("async_derived", derived_rst_n, 0);
        chk("async_run_en", run_en, 0);
        chk("async_count", cycle_count, 0);
        chk("async_state", state, 0);
        release_rst();
        tick(19);
        chk("re_e19_core", core_rst_n, 0);
        tick(1);
        chk("re_e20_core", core_rst_n, 1);
        // no lag, no drain, 4-bit counter
        @(negedge CLK);
        rst_n_w = 1;
        tick(19);
        chk("w_e19_core", core_rst_n_w, 0);
        chk("w_e19_derived", derived_rst_n_w, 0);
        tick(1);
        chk("w_e20_core", core_rst_n_w, 1);
        chk("w_e20_derived", derived_rst_n_w, 1);
        chk("w_e20_state", state_w, 2);
        tick(1);
        chk("w_e21_run_en", run_en_w, 1);
        tick(15);
        chk("w_e36_count", cycle_count_w, 15);
        tick(1);
        chk("w_e37_wrap", cycle_count_w, 0);
        finish_req_w = 1;
        tick(1);
        finish_req_w = 0;
        chk("w_e38_finish", finish_w, 1);
        chk("w_e38_state", state_w, 4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
